// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Contents: FSM state codes, grant side codes, access-timer width and the
// grant-selection helper used in the IDLE state.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t BUSY = 2'd1;
    localparam arb_state_t DONE = 2'd2;

    localparam logic GNT_IF  = 1'b0;
    localparam logic GNT_MEM = 1'b1;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
    localparam int CNT_W = 4;

    // A lone requester wins; on a conflict the side that did not win last time wins.
    function automatic logic pick_grant(input logic if_req_i, input logic mem_req_i,
                                        input logic last_grant_i);
        logic gnt;
        if (if_req_i && mem_req_i) begin
            gnt = ~last_grant_i;
        end else if (mem_req_i) begin
            gnt = GNT_MEM;
        end else begin
            gnt = GNT_IF;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of pipeline-side and RAM-side signals of the memory port arbiter.
// master: the pipeline stages plus the RAM array (drive requests, ram_rdata).
// slave : the arbiter (drives read data, ready pulses, stalls, RAM controls).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              proto_err;
    logic              stall_if;
    logic              stall_mem;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, proto_err, stall_if, stall_mem,
               ram_addr, ram_wdata, ram_re, ram_we
    );

    modport slave (
        input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, proto_err, stall_if, stall_mem,
               ram_addr, ram_wdata, ram_re, ram_we
    );

endinterface

// File: rtl/mem_port_arbiter_access_timer.sv
// Loadable down-counter that times one RAM access.
// Ports: Clk, Reset (sync, active-high), load/load_val (start a count),
// zero (count has reached 0; it stops there until reloaded).
module access_timer
    import mem_arb_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins, otherwise decrement and saturate at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified memory shared by IF (fetch) and MEM
// (load/store). Grants one access at a time, drives the RAM for MEM_LAT
// cycles, returns read data with a one-cycle ready pulse and produces the
// per-stage stall signals.
// Ports: Clk, Reset (sync, active-high), bus (slave side of
// mem_port_arbiter_if: requests, read data, ready, proto_err, stalls, RAM I/F).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        state_r, state_nxt_s;
    logic              last_grant_r, last_grant_nxt_s;
    logic              grant_s, req_any_s, mem_any_s;
    logic              timer_load_s, timer_zero_s;
    logic [ADDR_W-1:0] ram_addr_r, ram_addr_nxt_s;
    logic [DATA_W-1:0] ram_wdata_r, ram_wdata_nxt_s;
    logic              ram_re_r, ram_re_nxt_s;
    logic              ram_we_r, ram_we_nxt_s;
    logic              proto_err_r, proto_err_nxt_s;
    logic              if_ready_r, if_ready_nxt_s;
    logic              mem_ready_r, mem_ready_nxt_s;
    logic [DATA_W-1:0] if_rdata_r, if_rdata_nxt_s;
    logic [DATA_W-1:0] mem_rdata_r, mem_rdata_nxt_s;

    assign mem_any_s    = bus.mem_rd_req | bus.mem_wr_req;
    assign req_any_s    = bus.if_req | mem_any_s;
    assign grant_s      = pick_grant(bus.if_req, mem_any_s, last_grant_r);
    assign timer_load_s = (state_r == IDLE) && req_any_s;

    // The timer starts at MEM_LAT-1 so it reads zero in the last drive cycle.
    access_timer u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (timer_load_s),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .zero     (timer_zero_s)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (timer_zero_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; last_grant doubles as the side
    // owning the access in flight, since it is only rewritten at grant.
    always_comb begin
        last_grant_nxt_s = last_grant_r;
        ram_addr_nxt_s   = ram_addr_r;
        ram_wdata_nxt_s  = ram_wdata_r;
        ram_re_nxt_s     = ram_re_r;
        ram_we_nxt_s     = ram_we_r;
        proto_err_nxt_s  = 1'b0;
        if_ready_nxt_s   = 1'b0;
        mem_ready_nxt_s  = 1'b0;
        if_rdata_nxt_s   = if_rdata_r;
        mem_rdata_nxt_s  = mem_rdata_r;
        case (state_r)
            IDLE: begin
                if (req_any_s) begin
                    last_grant_nxt_s = grant_s;
                    if (grant_s == GNT_MEM) begin
                        // A store wins when both load and store are raised.
                        ram_addr_nxt_s  = bus.mem_addr;
                        ram_we_nxt_s    = bus.mem_wr_req;
                        ram_re_nxt_s    = ~bus.mem_wr_req;
                        ram_wdata_nxt_s = bus.mem_wr_req ? bus.mem_wdata : {DATA_W{1'b0}};
                        proto_err_nxt_s = bus.mem_rd_req & bus.mem_wr_req;
                    end else begin
                        ram_addr_nxt_s  = bus.if_addr;
                        ram_we_nxt_s    = 1'b0;
                        ram_re_nxt_s    = 1'b1;
                        ram_wdata_nxt_s = {DATA_W{1'b0}};
                    end
                end else begin
                    ram_addr_nxt_s  = {ADDR_W{1'b0}};
                    ram_wdata_nxt_s = {DATA_W{1'b0}};
                    ram_re_nxt_s    = 1'b0;
                    ram_we_nxt_s    = 1'b0;
                end
            end
            BUSY: begin
                if (timer_zero_s) begin
                    // Last drive cycle: capture RAM data and release the RAM.
                    ram_addr_nxt_s  = {ADDR_W{1'b0}};
                    ram_wdata_nxt_s = {DATA_W{1'b0}};
                    ram_re_nxt_s    = 1'b0;
                    ram_we_nxt_s    = 1'b0;
                    if (last_grant_r == GNT_IF) begin
                        if_ready_nxt_s = 1'b1;
                        if_rdata_nxt_s = bus.ram_rdata;
                    end else begin
                        mem_ready_nxt_s = 1'b1;
                        if (ram_re_r) begin
                            mem_rdata_nxt_s = bus.ram_rdata;
                        end else begin
                            mem_rdata_nxt_s = mem_rdata_r;
                        end
                    end
                end else begin
                    ram_addr_nxt_s  = ram_addr_r;
                    ram_wdata_nxt_s = ram_wdata_r;
                    ram_re_nxt_s    = ram_re_r;
                    ram_we_nxt_s    = ram_we_r;
                end
            end
            default: begin
                ram_addr_nxt_s  = {ADDR_W{1'b0}};
                ram_wdata_nxt_s = {DATA_W{1'b0}};
                ram_re_nxt_s    = 1'b0;
                ram_we_nxt_s    = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant_r <= GNT_IF;
            ram_addr_r   <= {ADDR_W{1'b0}};
            ram_wdata_r  <= {DATA_W{1'b0}};
            ram_re_r     <= 1'b0;
            ram_we_r     <= 1'b0;
            proto_err_r  <= 1'b0;
            if_ready_r   <= 1'b0;
            mem_ready_r  <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            mem_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            last_grant_r <= last_grant_nxt_s;
            ram_addr_r   <= ram_addr_nxt_s;
            ram_wdata_r  <= ram_wdata_nxt_s;
            ram_re_r     <= ram_re_nxt_s;
            ram_we_r     <= ram_we_nxt_s;
            proto_err_r  <= proto_err_nxt_s;
            if_ready_r   <= if_ready_nxt_s;
            mem_ready_r  <= mem_ready_nxt_s;
            if_rdata_r   <= if_rdata_nxt_s;
            mem_rdata_r  <= mem_rdata_nxt_s;
        end
    end

    assign bus.ram_addr  = ram_addr_r;
    assign bus.ram_wdata = ram_wdata_r;
    assign bus.ram_re    = ram_re_r;
    assign bus.ram_we    = ram_we_r;
    assign bus.proto_err = proto_err_r;
    assign bus.if_ready  = if_ready_r;
    assign bus.mem_ready = mem_ready_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.mem_rdata = mem_rdata_r;
    // Stalls are combinational so the hazard unit sees them in the request cycle.
    assign bus.stall_if  = bus.if_req & ~if_ready_r;
    assign bus.stall_mem = mem_any_s & ~mem_ready_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. It sequences multi-cycle RAM accesses and returns read data with a one-cycle ready pulse. It also generates per-stage stall signals that feed the hazard detection unit and gate the PC, IF/ID and EX/MEM enables. It sits between the pipeline and the memory array.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 2, number of cycles the RAM is driven per access; legal range 1..15.

Ports:
Clk  in  1  clock
Reset  in  1  synchronous active-high reset
if_req  in  1  IF read request; held until if_ready
if_addr  in  ADDR_W  IF fetch address
if_rdata  out  DATA_W  fetched instruction; valid while if_ready=1
if_ready  out  1  one-cycle completion pulse for IF
mem_rd_req  in  1  MEM-stage load request
mem_wr_req  in  1  MEM-stage store request
mem_addr  in  ADDR_W  data address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data; valid while mem_ready=1
mem_ready  out  1  one-cycle completion pulse for MEM (loads and stores)
proto_err  out  1  one-cycle pulse: mem_rd_req and mem_wr_req were both high at grant
stall_if  out  1  if_req & ~if_ready (combinational)
stall_mem  out  1  (mem_rd_req|mem_wr_req) & ~mem_ready (combinational)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
ram_re  out  1  RAM read enable
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data; sampled at the end of the last access cycle

Behaviour:
- Reset values: all outputs 0, except the combinational stalls, which follow their inputs. State=IDLE, last_grant=IF.
- FSM states:
  - IDLE: sample requests at the clock edge.
  - BUSY: RAM driven; counter counts MEM_LAT-1 down to 0.
  - DONE: ready pulse; all requests are ignored.
- Transitions: IDLE -> BUSY on any request. BUSY -> DONE when count==0. DONE -> IDLE always.
- Grant, evaluated in IDLE:
  - Only one side requesting: that side wins.
  - Both requesting: the side opposite last_grant wins.
  - last_grant is updated at grant. Because it resets to IF, the first conflict goes to MEM.
- On grant (edge at the end of IDLE cycle t), register for cycles t+1..t+MEM_LAT:
  - ram_addr: granted address.
  - ram_re: 1 for a read.
  - ram_we: 1 for a store.
  - ram_wdata: mem_wdata for a store.
- If both mem_rd_req and mem_wr_req are high at grant, the access is a write and proto_err pulses in cycle t+1.
- ram_re/ram_we/ram_addr/ram_wdata stay constant for exactly MEM_LAT cycles, then drop to 0 in DONE.
- Read data: ram_rdata is sampled at the end of cycle t+MEM_LAT. The granted side's rdata register loads it, and that side's ready is 1 in cycle t+MEM_LAT+1 (DONE).
- Latency: request to ready = MEM_LAT+1 cycles. The minimum request-to-request spacing per access is MEM_LAT+2 cycles.
- if_rdata and mem_rdata hold their value until that side's next read completes; stores do not alter mem_rdata.
- Requesters must hold req, addr and wdata stable until ready. Changes during BUSY are ignored because the values are latched at grant.
- A request that is still high in the cycle after DONE is treated as a new access.
- Requests dropped before grant are never served.
- Reset mid-access: state goes to IDLE and ram_we/ram_re go to 0 at the next edge. The access is abandoned, so a truncated write has undefined memory content, and no ready is issued.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state localparams IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - grant encoding GNT_IF=1'b0, GNT_MEM=1'b1;
  - the MEM_LAT width constant CNT_W=4.
- Sub-module access_timer: loadable down-counter (Clk, Reset, load, load_val, zero). It is instantiated once.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x0000_0040, MEM_LAT=2, and ram_rdata=0x2008_0005 in cycle t+2 -> ram_re=1 and ram_addr=0x40 in cycles t+1..t+2; if_ready=1 and if_rdata=0x2008_0005 in cycle t+3; stall_if=1 in cycles t..t+2.
2. mem_wr_req=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF -> ram_we=1 for 2 cycles with that address and data; mem_ready pulses in cycle t+3; mem_rdata unchanged.
3. if_req and mem_rd_req both high from reset -> MEM is granted first and mem_ready comes at t+3; IF is granted in the IDLE cycle t+4 and if_ready comes at t+7. Holding both requests continuously alternates grants MEM, IF, MEM, IF.
4. mem_rd_req=mem_wr_req=1 -> a write is performed, proto_err=1 in cycle t+1 only, and mem_ready comes at t+3.
5. Reset asserted in cycle t+1 of a write -> ram_we=0 in cycle t+2, no mem_ready, and a fresh if_req after reset is served normally.
6. MEM_LAT=1 and MEM_LAT=15 runs of scenario 1 -> if_ready at t+2 and t+16 respectively; the RAM enable is high for exactly MEM_LAT cycles.
